genetic_circuit_seq: RTL and testbench



---
 rtl/genetic_pkg.sv | 32 +++
 rtl/genetic_accumulator.sv | 61 ++++++
 rtl/genetic_circuit_seq.sv | 83 ++++++++
 tb/tb_genetic_circuit_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/genetic_pkg.sv
// Shared definitions for the genetic repressor circuit: field offsets, output
// offsets, accumulator state encoding and the two target logic functions.
package genetic_pkg;

  localparam int FIELD_W = 5;
  localparam int OUT_W   = 2;

  localparam int IDX_A = 0;
  localparam int IDX_B = 1;
  localparam int IDX_C = 2;
  localparam int IDX_D = 3;
  localparam int IDX_E = 4;

  localparam int OUT1 = 0;
  localparam int OUT2 = 1;

  typedef enum logic {
    ACC_OFF = 1'b0,
    ACC_ON  = 1'b1
  } acc_state_t;

  function automatic logic target_t1(input logic a, input logic b, input logic c);
    return ~((~a & b) | (c & ~b));
  endfunction

  // out2 is pulled high by t1 as well as by its own d/e repressor pair
  function automatic logic target_t2(input logic a, input logic b, input logic c,
                                     input logic d, input logic e);
    return (d & ~e) | target_t1(a, b, c);
  endfunction

endpackage

// File: rtl/genetic_accumulator.sv
// One saturating accumulator with ON/OFF hysteresis, an optional freeze while
// ON (latch hold) and a clear that forces the counter back to rest.
module genetic_accumulator
  import genetic_pkg::*;
#(
  parameter int DELAY = 4,
  parameter int CW    = $clog2(DELAY + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic target,
  input  logic latch_hold_en,
  input  logic latch_clr,
  output logic state_on,
  output logic state_on_nxt
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DELAY);

  acc_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= ACC_OFF;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Clear dominates everything; a latched ON output ignores its target.
  // Otherwise the state only moves when the counter hits an end stop.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (latch_clr) begin
      cnt_d   = '0;
      state_d = ACC_OFF;
    end else if (latch_hold_en && (state_q == ACC_ON)) begin
      cnt_d   = CNT_MAX;
      state_d = ACC_ON;
    end else begin
      if (target) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
      end else begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
      end
      if (cnt_d == CNT_MAX) begin
        state_d = ACC_ON;
      end else if (cnt_d == '0) begin
        state_d = ACC_OFF;
      end
    end
  end

  assign state_on     = (state_q == ACC_ON);
  assign state_on_nxt = (state_d == ACC_ON);

endmodule

// File: rtl/genetic_circuit_seq.sv
// CH-channel sequential genetic logic block with delayed outputs and a change
// event port. Define GENETIC_LATCH_EN to honour the per-channel latch_mode.
module genetic_circuit_seq
  import genetic_pkg::*;
#(
  parameter int CH    = 2,
  parameter int DELAY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FIELD_W*CH-1:0] in_bus,
  input  logic [CH-1:0]         latch_mode,
  input  logic [CH-1:0]         latch_clr,
  output logic [OUT_W*CH-1:0]   out_bus,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [OUT_W*CH-1:0]   evt_data,
  output logic                  evt_ovf
);

  localparam int CW = $clog2(DELAY + 1);

  logic [OUT_W*CH-1:0] target;
  logic [OUT_W*CH-1:0] out_q;
  logic [OUT_W*CH-1:0] out_nxt;
  logic [CH-1:0]       hold_en;
  logic                out_change;

`ifdef GENETIC_LATCH_EN
  assign hold_en = latch_mode;
`else
  logic unused_latch_mode;
  assign hold_en           = '0;
  assign unused_latch_mode = ^latch_mode;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [FIELD_W-1:0] field;
    assign field = in_bus[FIELD_W*i +: FIELD_W];

    assign target[OUT_W*i + OUT1] = target_t1(field[IDX_A], field[IDX_B], field[IDX_C]);
    assign target[OUT_W*i + OUT2] = target_t2(field[IDX_A], field[IDX_B], field[IDX_C],
                                              field[IDX_D], field[IDX_E]);

    for (genvar k = 0; k < OUT_W; k++) begin : g_out
      genetic_accumulator #(
        .DELAY(DELAY),
        .CW   (CW)
      ) u_acc (
        .clk          (clk),
        .reset        (reset),
        .target       (target[OUT_W*i + k]),
        .latch_hold_en(hold_en[i]),
        .latch_clr    (latch_clr[i]),
        .state_on     (out_q[OUT_W*i + k]),
        .state_on_nxt (out_nxt[OUT_W*i + k])
      );
    end
  end

  assign out_bus    = out_q;
  assign out_change = (out_nxt != out_q);

  // Snapshot the new output on the edge it changes so the event carries no
  // extra latency; a change that cannot be taken is flagged, never queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_data  <= '0;
      evt_ovf   <= 1'b0;
    end else if (out_change) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_data  <= out_nxt;
      end else begin
        evt_ovf <= 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_genetic_circuit_seq.sv
// Randomised and directed bench for genetic_circuit_seq (CH=2, DELAY=4) against
// a behavioural reference model; follows GENETIC_LATCH_EN when defined.
module tb_genetic_circuit_seq;

  localparam int CH    = 2;
  localparam int DELAY = 4;
  localparam int NOUT  = 2 * CH;

`ifdef GENETIC_LATCH_EN
  localparam bit LATCH_EN = 1'b1;
`else
  localparam bit LATCH_EN = 1'b0;
`endif

  localparam logic [4:0] F_HOLD = 5'b00010;
  localparam logic [4:0] F_ON   = 5'b00000;

  logic            clk = 1'b0;
  logic            reset;
  logic [5*CH-1:0] in_bus;
  logic [CH-1:0]   latch_mode;
  logic [CH-1:0]   latch_clr;
  logic [NOUT-1:0] out_bus;
  logic            evt_valid;
  logic            evt_ready;
  logic [NOUT-1:0] evt_data;
  logic            evt_ovf;

  int checks   = 0;
  int failures = 0;

  int              m_cnt [NOUT];
  bit              m_on  [NOUT];
  logic [NOUT-1:0] m_out;
  logic            m_evt_valid;
  logic [NOUT-1:0] m_evt_data;
  logic            m_evt_ovf;

  genetic_circuit_seq #(
    .CH   (CH),
    .DELAY(DELAY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (in_bus),
    .latch_mode(latch_mode),
    .latch_clr (latch_clr),
    .out_bus   (out_bus),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_ovf   (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference: t1 equals a when b is set, otherwise the inverse of c.
  task automatic modelStep(input logic [5*CH-1:0] ib, input logic [CH-1:0] lm,
                           input logic [CH-1:0] lc, input logic rdy, input logic rst);
    logic [NOUT-1:0] prev;
    bit a, b, c, d, e, t1, tgt;
    int ch;
    prev = m_out;
    if (rst) begin
      for (int j = 0; j < NOUT; j++) begin
        m_cnt[j] = 0;
        m_on[j]  = 0;
      end
      m_out       = '0;
      m_evt_valid = 1'b0;
      m_evt_data  = '0;
      m_evt_ovf   = 1'b0;
      return;
    end
    for (int j = 0; j < NOUT; j++) begin
      ch  = j / 2;
      a   = ib[5*ch + 0];
      b   = ib[5*ch + 1];
      c   = ib[5*ch + 2];
      d   = ib[5*ch + 3];
      e   = ib[5*ch + 4];
      t1  = b ? a : !c;
      tgt = (j % 2 == 0) ? t1 : ((d && !e) || t1);
      if (lc[ch]) begin
        m_cnt[j] = 0;
        m_on[j]  = 0;
      end else if (LATCH_EN && lm[ch] && m_on[j]) begin
        m_cnt[j] = DELAY;
      end else begin
        m_cnt[j] = tgt ? ((m_cnt[j] + 1 > DELAY) ? DELAY : m_cnt[j] + 1)
                       : ((m_cnt[j] - 1 < 0) ? 0 : m_cnt[j] - 1);
        if (m_cnt[j] == DELAY) m_on[j] = 1;
        else if (m_cnt[j] == 0) m_on[j] = 0;
      end
      m_out[j] = m_on[j];
    end
    if (m_out != prev) begin
      if (!m_evt_valid || rdy) begin
        m_evt_valid = 1'b1;
        m_evt_data  = m_out;
      end else begin
        m_evt_ovf = 1'b1;
      end
    end else if (m_evt_valid && rdy) begin
      m_evt_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [5*CH-1:0] ib, input logic [CH-1:0] lm,
                               input logic [CH-1:0] lc, input logic rdy, input logic rst);
    in_bus     = ib;
    latch_mode = lm;
    latch_clr  = lc;
    evt_ready  = rdy;
    reset      = rst;
    @(posedge clk);
    #1;
    modelStep(ib, lm, lc, rdy, rst);
    checkOutput("out_bus", 32'(out_bus), 32'(m_out));
    checkOutput("evt_valid", 32'(evt_valid), 32'(m_evt_valid));
    checkOutput("evt_data", 32'(evt_data), 32'(m_evt_data));
    checkOutput("evt_ovf", 32'(evt_ovf), 32'(m_evt_ovf));
  endtask

  task automatic runCycles(input int n, input logic [5*CH-1:0] ib, input logic [CH-1:0] lm,
                           input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(ib, lm, '0, rdy, 1'b0);
  endtask

  initial begin
    logic [5*CH-1:0] rib;
    m_out       = '0;
    m_evt_valid = 1'b0;
    m_evt_data  = '0;
    m_evt_ovf   = 1'b0;
    for (int j = 0; j < NOUT; j++) begin
      m_cnt[j] = 0;
      m_on[j]  = 0;
    end

    applyStimulus({F_HOLD, F_HOLD}, '0, '0, 1'b0, 1'b1);
    checkOutput("rst_out", 32'(out_bus), 32'h0);
    checkOutput("rst_valid", 32'(evt_valid), 32'h0);
    checkOutput("rst_data", 32'(evt_data), 32'h0);
    checkOutput("rst_ovf", 32'(evt_ovf), 32'h0);
    runCycles(3, {F_HOLD, F_HOLD}, '0, 1'b0);
    checkOutput("hold_out", 32'(out_bus), 32'h0);

    runCycles(3, {F_HOLD, F_ON}, '0, 1'b0);
    checkOutput("rise_early", 32'(out_bus), 32'h0);
    runCycles(1, {F_HOLD, F_ON}, '0, 1'b0);
    checkOutput("rise_out", 32'(out_bus), 32'h3);
    checkOutput("rise_valid", 32'(evt_valid), 32'h1);
    checkOutput("rise_data", 32'(evt_data), 32'h3);

    runCycles(3, {F_ON, F_ON}, '0, 1'b0);
    runCycles(4, {F_HOLD, F_ON}, '0, 1'b0);
    checkOutput("glitch_out", 32'(out_bus), 32'h3);
    checkOutput("glitch_ovf", 32'(evt_ovf), 32'h0);

    runCycles(2, {F_HOLD, F_HOLD}, '0, 1'b0);
    runCycles(3, {F_HOLD, F_ON}, '0, 1'b0);
    checkOutput("hyst_out", 32'(out_bus), 32'h3);

    runCycles(4, {F_HOLD, F_HOLD}, '0, 1'b0);
    runCycles(4, {F_HOLD, F_ON}, '0, 1'b0);
    checkOutput("ovf_data", 32'(evt_data), 32'h3);
    checkOutput("ovf_flag", 32'(evt_ovf), 32'h1);
    runCycles(1, {F_HOLD, F_ON}, '0, 1'b1);
    checkOutput("ovf_drain", 32'(evt_valid), 32'h0);
    checkOutput("ovf_sticky", 32'(evt_ovf), 32'h1);

    runCycles(4, {F_ON, F_ON}, 2'b10, 1'b1);
    checkOutput("latch_on", 32'(out_bus), 32'hF);
    runCycles(10, {F_HOLD, F_ON}, 2'b10, 1'b1);
    checkOutput("latch_hold", 32'(out_bus[3:2]), LATCH_EN ? 32'h3 : 32'h0);
    applyStimulus({F_ON, F_ON}, 2'b10, 2'b10, 1'b1, 1'b0);
    checkOutput("latch_clr", 32'(out_bus), 32'h3);
    runCycles(3, {F_ON, F_ON}, 2'b10, 1'b1);
    checkOutput("clr_early", 32'(out_bus), 32'h3);
    runCycles(1, {F_ON, F_ON}, 2'b10, 1'b1);
    checkOutput("clr_rerise", 32'(out_bus), 32'hF);

    runCycles(4, {F_HOLD, F_HOLD}, '0, 1'b1);
    runCycles(3, {F_ON, F_ON}, '0, 1'b1);
    applyStimulus({F_ON, F_ON}, '0, '0, 1'b1, 1'b1);
    checkOutput("midrst_out", 32'(out_bus), 32'h0);
    runCycles(3, {F_ON, F_ON}, '0, 1'b1);
    checkOutput("midrst_early", 32'(out_bus), 32'h0);
    runCycles(1, {F_ON, F_ON}, '0, 1'b1);
    checkOutput("midrst_rise", 32'(out_bus), 32'hF);

    rib = 10'($urandom);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 5) == 0) rib = 10'($urandom);
      applyStimulus(rib, 2'($urandom),
                    ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
